univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register: the successor to the fixed 4-bit parallel-in/parallel-out register. Supports hold, parallel load, logical shift left/right with serial inputs, rotate left/right and synchronous clear. Includes a saturating shift counter with a `done` flag, so the block can act as a serialiser or deserialiser in the day-to-day shift-register library. All state updates occur on the rising edge of one clock.

## Interface
- `WIDTH`, default 8: register width in bits. Legal range is ≥ 2.
- `CW`, default `$clog2(WIDTH+1)`: shift-counter width. Derived; do not override.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  operation enable. When low, all state holds regardless of `mode`.
- `mode`  in  3  operation select; see Operation.
- `parallel_in`  in  WIDTH  data for parallel load.
- `serial_in_lsb`  in  1  bit entering bit 0 on shift left.
- `serial_in_msb`  in  1  bit entering bit WIDTH-1 on shift right.
- `parallel_out`  out  WIDTH  register contents (registered).
- `serial_out_msb`  out  1  equals `parallel_out[WIDTH-1]`.
- `serial_out_lsb`  out  1  equals `parallel_out[0]`.
- `shift_count`  out  CW  number of shift/rotate operations since the last load, clear or reset. Saturates at WIDTH.
- `done`  out  1  high when `shift_count == WIDTH`.

## Operation
- Priority order: `rst`, then `en`, then `mode`.
- `rst`=1 at an edge:
  - `parallel_out` = 0, `shift_count` = 0.
  - Therefore `done` = 0, `serial_out_msb` = 0, `serial_out_lsb` = 0.
  - `en`, `mode` and the data inputs are ignored.
- `en`=0 at an edge: register and counter hold.
- Operations when `en`=1. Here `q` is the register and `sc` is `shift_count`:
  - `000` hold: `q` and `sc` unchanged.
  - `001` shift left: `q <= {q[WIDTH-2:0], serial_in_lsb}`; `sc++`.
  - `010` shift right: `q <= {serial_in_msb, q[WIDTH-1:1]}`; `sc++`.
  - `011` parallel load: `q <= parallel_in`; `sc <= 0`.
  - `100` rotate left: `q <= {q[WIDTH-2:0], q[WIDTH-1]}`; `sc++`.
  - `101` rotate right: `q <= {q[0], q[WIDTH-1:1]}`; `sc++`.
  - `110` clear: `q <= 0`; `sc <= 0`.
  - `111` reserved: behaves exactly as hold.
- `sc++` saturates: when `sc == WIDTH`, further shifts and rotates still move data, but `sc` stays at WIDTH.
- `done` and both serial outputs are combinational decodes of registered state. They have no direct path from any input.
- The counter is a simple operation counter. Shifts and rotates count equally and are never distinguished.

## Timing
- Latency is one cycle. Inputs sampled at edge N appear on `parallel_out` after edge N.
- No handshake. Every enabled edge performs exactly one operation.
- `done` rises in the same cycle that `shift_count` reaches WIDTH, i.e. after the WIDTH-th shift edge.
- `done` falls after the edge that performs a load, a clear or a reset.
- Reset mid-shift: the next edge with `rst`=1 zeroes all state. Partial data is discarded.
- Changing `mode` between cycles is legal at every edge. There is no settling cycle.
- Load and shift on the same edge cannot occur, because `mode` is one-hot in effect. A load always restarts the count.

## Test plan
All scenarios use `WIDTH`=4.
- Reset: hold `rst`=1 with `en`=1, `mode`=`011`, `parallel_in`=`1101` → `parallel_out`=`0000`, `shift_count`=0, `done`=0.
- Load and hold: load `1101`, then `mode`=`000` for 2 cycles, then `en`=0 with `mode`=`011` and `parallel_in`=`0110` → output stays `1101`.
- Shift left and saturation: load `1101`, then shift left with `serial_in_lsb`=0 for 5 edges:
  - Outputs: `1010`, `0100`, `1000`, `0000`, `0000`.
  - `shift_count`: 1, 2, 3, 4, 4.
  - `done` high from the 4th edge onward.
  - `serial_out_msb` after the load = 1.
- Shift right with fill: load `1010`, then shift right with `serial_in_msb`=1 for 2 edges → `1101`, then `1110`; `serial_out_lsb` = 1, then 0.
- Rotates:
  - Load `1001`, rotate left twice → `0011`, then `0110`.
  - Then rotate right once → `0011`.
  - `shift_count`=3.
- Clear, reserved mode and mid-operation reset:
  - Load `1111`, shift left twice, then `mode`=`110` → `0000`, count 0.
  - Load `0101`, `mode`=`111` → unchanged.
  - Shift once, then assert `rst` → `0000`, count 0, `done`=0.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// Bus bundle for the universal shift register: control, data inputs and
// observed register state. The register drives the slave side; the
// controlling agent (serialiser front end, test bench) drives the master side.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_in_lsb;
  logic             serial_in_msb;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out_msb;
  logic             serial_out_lsb;
  logic [CW-1:0]    shift_count;
  logic             done;

  modport master (
    output en,
    output mode,
    output parallel_in,
    output serial_in_lsb,
    output serial_in_msb,
    input  parallel_out,
    input  serial_out_msb,
    input  serial_out_lsb,
    input  shift_count,
    input  done
  );

  modport slave (
    input  en,
    input  mode,
    input  parallel_in,
    input  serial_in_lsb,
    input  serial_in_msb,
    output parallel_out,
    output serial_out_msb,
    output serial_out_lsb,
    output shift_count,
    output done
  );

endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, logical shift left/right
// with serial fill, rotate left/right and clear, plus a saturating count of
// shift/rotate operations since the last load, clear or reset. The count lets
// the block act as a serialiser/deserialiser: done marks WIDTH shifts.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst,
  univ_shift_reg_if.slave  bus
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_RSVD  = 3'b111;

  localparam logic [CW-1:0] SC_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [CW-1:0]    sc_q;
  logic [CW-1:0]    sc_d;

  // Counter advance that parks at WIDTH: data keeps moving past that point,
  // only the count stops.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    logic [CW-1:0] res;
    if (cnt == SC_MAX) begin
      res = cnt;
    end else begin
      res = cnt + CW'(1);
    end
    return res;
  endfunction

  // Next-state selection: enable gates everything, then mode picks one op.
  always_comb begin
    q_d  = q_q;
    sc_d = sc_q;
    if (bus.en) begin
      case (bus.mode)
        MODE_HOLD: begin
          q_d  = q_q;
          sc_d = sc_q;
        end
        MODE_SHL: begin
          q_d  = {q_q[WIDTH-2:0], bus.serial_in_lsb};
          sc_d = sat_inc(sc_q);
        end
        MODE_SHR: begin
          q_d  = {bus.serial_in_msb, q_q[WIDTH-1:1]};
          sc_d = sat_inc(sc_q);
        end
        MODE_LOAD: begin
          q_d  = bus.parallel_in;
          sc_d = '0;
        end
        MODE_ROL: begin
          q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sc_d = sat_inc(sc_q);
        end
        MODE_ROR: begin
          q_d  = {q_q[0], q_q[WIDTH-1:1]};
          sc_d = sat_inc(sc_q);
        end
        MODE_CLEAR: begin
          q_d  = '0;
          sc_d = '0;
        end
        MODE_RSVD: begin
          q_d  = q_q;
          sc_d = sc_q;
        end
        default: begin
          q_d  = q_q;
          sc_d = sc_q;
        end
      endcase
    end else begin
      q_d  = q_q;
      sc_d = sc_q;
    end
  end

  // State registers; synchronous reset discards any partial shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= '0;
      sc_q <= '0;
    end else begin
      q_q  <= q_d;
      sc_q <= sc_d;
    end
  end

  // Outputs are the registers themselves or pure decodes of them, so no
  // input reaches an output without passing through a flop.
  assign bus.parallel_out   = q_q;
  assign bus.shift_count    = sc_q;
  assign bus.serial_out_msb = q_q[WIDTH-1];
  assign bus.serial_out_lsb = q_q[0];
  assign bus.done           = (sc_q == SC_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg at WIDTH=4: directed scenarios from
// the block's test plan, then randomized operations, all compared against an
// arithmetic reference model.
module tb_univ_shift_reg;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic clk;
  logic rst;

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference state: register value as an integer, count as an integer.
  int m_q;
  int m_sc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour written from the operation table with plain arithmetic.
  task automatic model_update(input bit r, input bit e, input int md, input int pin,
                              input int sl, input int sm);
    int mod;
    mod = 1 << W;
    if (r) begin
      m_q  = 0;
      m_sc = 0;
    end else if (e) begin
      case (md)
        1: begin m_q = (m_q * 2 + sl) % mod;               if (m_sc < W) m_sc++; end
        2: begin m_q = m_q / 2 + sm * (mod / 2);           if (m_sc < W) m_sc++; end
        3: begin m_q = pin; m_sc = 0; end
        4: begin m_q = (m_q * 2) % mod + m_q / (mod / 2);  if (m_sc < W) m_sc++; end
        5: begin m_q = m_q / 2 + (m_q % 2) * (mod / 2);    if (m_sc < W) m_sc++; end
        6: begin m_q = 0; m_sc = 0; end
        default: ;
      endcase
    end
  endtask

  // Apply one edge's worth of inputs, advance the model, compare all outputs.
  task automatic step(input bit r, input bit e, input int md, input int pin,
                      input int sl, input int sm);
    rst               = r;
    bus.en            = e;
    bus.mode          = 3'(md);
    bus.parallel_in   = W'(pin);
    bus.serial_in_lsb = sl[0];
    bus.serial_in_msb = sm[0];
    @(posedge clk);
    model_update(r, e, md, pin, sl, sm);
    #1;
    check_eq("parallel_out", 32'(bus.parallel_out), 32'(m_q));
    check_eq("shift_count",  32'(bus.shift_count),  32'(m_sc));
    check_eq("done",         32'(bus.done),         32'(m_sc == W));
    check_eq("serial_out_msb", 32'(bus.serial_out_msb), 32'((m_q >> (W - 1)) & 1));
    check_eq("serial_out_lsb", 32'(bus.serial_out_lsb), 32'(m_q & 1));
  endtask

  initial begin
    int sl_exp [5];
    int sc_exp [5];
    n_vec = 0;
    n_err = 0;
    m_q   = 0;
    m_sc  = 0;
    rst               = 1'b1;
    bus.en            = 1'b0;
    bus.mode          = 3'b000;
    bus.parallel_in   = '0;
    bus.serial_in_lsb = 1'b0;
    bus.serial_in_msb = 1'b0;
    @(negedge clk);

    // Reset dominates enable and load.
    step(1, 1, 3, 4'b1101, 0, 0);
    step(1, 1, 3, 4'b1101, 0, 0);
    check_eq("rst_pout", 32'(bus.parallel_out), 32'd0);
    check_eq("rst_sc",   32'(bus.shift_count),  32'd0);
    check_eq("rst_done", 32'(bus.done),         32'd0);

    // Load and hold; disabled load must not take effect.
    step(0, 1, 3, 4'b1101, 0, 0);
    step(0, 1, 0, 4'b0000, 0, 0);
    step(0, 1, 0, 4'b0000, 0, 0);
    step(0, 0, 3, 4'b0110, 0, 0);
    check_eq("hold_pout", 32'(bus.parallel_out), 32'b1101);

    // Shift left with zero fill through saturation.
    sl_exp = '{4'b1010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    sc_exp = '{1, 2, 3, 4, 4};
    step(0, 1, 3, 4'b1101, 0, 0);
    check_eq("load_msb", 32'(bus.serial_out_msb), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 0, 0, 0);
      check_eq("shl_pout", 32'(bus.parallel_out), 32'(sl_exp[i]));
      check_eq("shl_sc",   32'(bus.shift_count),  32'(sc_exp[i]));
      check_eq("shl_done", 32'(bus.done),         32'(i >= 3));
    end

    // Shift right with one fill.
    step(0, 1, 3, 4'b1010, 0, 0);
    step(0, 1, 2, 0, 0, 1);
    check_eq("shr1_pout", 32'(bus.parallel_out), 32'b1101);
    check_eq("shr1_lsb",  32'(bus.serial_out_lsb), 32'd1);
    step(0, 1, 2, 0, 0, 1);
    check_eq("shr2_pout", 32'(bus.parallel_out), 32'b1110);
    check_eq("shr2_lsb",  32'(bus.serial_out_lsb), 32'd0);

    // Rotates.
    step(0, 1, 3, 4'b1001, 0, 0);
    step(0, 1, 4, 0, 0, 0);
    check_eq("rol1", 32'(bus.parallel_out), 32'b0011);
    step(0, 1, 4, 0, 0, 0);
    check_eq("rol2", 32'(bus.parallel_out), 32'b0110);
    step(0, 1, 5, 0, 0, 0);
    check_eq("ror1", 32'(bus.parallel_out), 32'b0011);
    check_eq("rot_sc", 32'(bus.shift_count), 32'd3);

    // Clear, reserved mode, reset mid-operation.
    step(0, 1, 3, 4'b1111, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 6, 0, 0, 0);
    check_eq("clr_pout", 32'(bus.parallel_out), 32'd0);
    check_eq("clr_sc",   32'(bus.shift_count),  32'd0);
    step(0, 1, 3, 4'b0101, 0, 0);
    step(0, 1, 7, 4'b1010, 1, 1);
    check_eq("rsvd_pout", 32'(bus.parallel_out), 32'b0101);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 1);
    check_eq("rst2_pout", 32'(bus.parallel_out), 32'd0);
    check_eq("rst2_sc",   32'(bus.shift_count),  32'd0);
    check_eq("rst2_done", 32'(bus.done),         32'd0);

    // Randomized operations, biased toward shifts so saturation is reached often.
    for (int i = 0; i < 600; i++) begin
      bit r;
      bit e;
      int md;
      r  = ($urandom_range(0, 63) == 0);
      e  = ($urandom_range(0, 3) != 0);
      md = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7))
                                       : int'($urandom_range(1, 2)) + 3 * int'($urandom_range(0, 1));
      if (md == 7 && $urandom_range(0, 1) == 0) md = 4;
      step(r, e, md, int'($urandom_range(0, (1 << W) - 1)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
